// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared cache-controller constants, field widths and FSM state type
package cc_pkg;

  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam int         CC_LINE_BEATS  = 8;
  localparam logic [3:0] CC_ARLEN       = 4'd7;

  // Line address fields: offset [5:0], index [14:6], tag [31:15]
  localparam int CC_OFFSET_LSB = 0;
  localparam int CC_OFFSET_W   = 6;
  localparam int CC_INDEX_LSB  = 6;
  localparam int CC_INDEX_W    = 9;
  localparam int CC_TAG_LSB    = 15;
  localparam int CC_TAG_W      = 17;

  typedef enum logic {
    IDLE   = 1'b0,
    AR_REQ = 1'b1
  } cc_miss_state_e;

endpackage

// File: rtl/cc_miss_addr_fifo.sv
// rtl/cc_miss_addr_fifo.sv - synchronous show-ahead FIFO with occupancy count
module cc_miss_addr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  // Extra pointer MSB separates the full and empty cases when low bits match
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en && !full) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + PW'(1);
      end
      if (rd_en && !empty) rptr <= rptr + PW'(1);
    end
  end

endmodule

// File: rtl/cc_miss_req_unit.sv
// rtl/cc_miss_req_unit.sv - issues one AXI AR wrap burst per line miss and queues miss addresses
module cc_miss_req_unit
  import cc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_req_i,
  input  logic [ADDR_W-1:0]             miss_addr_i,
  output logic                          miss_ready_o,
  output logic [ADDR_W-1:0]             mem_araddr_o,
  output logic [3:0]                    mem_arlen_o,
  output logic [2:0]                    mem_arsize_o,
  output logic [1:0]                    mem_arburst_o,
  output logic                          mem_arvalid_o,
  input  logic                          mem_arready_i,
  output logic                          miss_addr_fifo_empty_o,
  output logic [ADDR_W-1:0]             miss_addr_fifo_rdata_o,
  input  logic                          miss_addr_fifo_rden_i,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding_o
);

  cc_miss_state_e state, state_next;
  logic           fifo_full;
  logic           accept;

  assign accept        = miss_req_i && miss_ready_o;
  assign mem_arvalid_o = (state == AR_REQ);
  assign mem_arlen_o   = CC_ARLEN;
  assign mem_arsize_o  = AXI_SIZE_8B;
  assign mem_arburst_o = AXI_BURST_WRAP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_araddr_o <= '0;
    end else begin
      state <= state_next;
      // Critical-word-first: wrap burst starts at the 8-byte beat holding the miss
      if (accept) mem_araddr_o <= {miss_addr_i[ADDR_W-1:3], 3'b000};
    end
  end

  always_comb begin
    state_next   = state;
    miss_ready_o = 1'b0;
    case (state)
      IDLE: begin
        miss_ready_o = !fifo_full && !rst;
        if (miss_req_i && miss_ready_o) state_next = AR_REQ;
      end
      AR_REQ: begin
        if (mem_arready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Entry is written on the accept edge, so it always precedes the AR handshake
  cc_miss_addr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_miss_addr_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (accept),
    .wdata (miss_addr_i),
    .rd_en (miss_addr_fifo_rden_i),
    .rdata (miss_addr_fifo_rdata_o),
    .empty (miss_addr_fifo_empty_o),
    .full  (fifo_full),
    .count (outstanding_o)
  );

endmodule

// File: tb/tb_cc_miss_req_unit.sv
// tb/tb_cc_miss_req_unit.sv - directed self-checking bench for cc_miss_req_unit
module tb_cc_miss_req_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic        fifo_rden;
  logic [2:0]  outstanding;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cc_miss_req_unit #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .miss_req_i             (miss_req),
    .miss_addr_i            (miss_addr),
    .miss_ready_o           (miss_ready),
    .mem_araddr_o           (araddr),
    .mem_arlen_o            (arlen),
    .mem_arsize_o           (arsize),
    .mem_arburst_o          (arburst),
    .mem_arvalid_o          (arvalid),
    .mem_arready_i          (arready),
    .miss_addr_fifo_empty_o (fifo_empty),
    .miss_addr_fifo_rdata_o (fifo_rdata),
    .miss_addr_fifo_rden_i  (fifo_rden),
    .outstanding_o          (outstanding)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; arready = 1'b0; fifo_rden = 1'b0;
    tick(); tick();
    vectors++; if (miss_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %0h expected 0", miss_ready); end
    vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL reset_arvalid: got %0h expected 0", arvalid); end
    vectors++; if (araddr !== 32'h0) begin miscompares++; $display("FAIL reset_araddr: got %h expected 0", araddr); end
    vectors++; if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %0h expected 1", fifo_empty); end
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    rst = 1'b0;
    #1;
    vectors++; if (miss_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %0h expected 1", miss_ready); end
  endtask

  task automatic test_single_miss();
    arready = 1'b1; miss_req = 1'b1; miss_addr = 32'h0001_2348;
    #1;
    vectors++; if (miss_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %0h expected 1", miss_ready); end
    tick();
    miss_req = 1'b0;
    vectors++; if (arvalid !== 1'b1) begin miscompares++; $display("FAIL single_arvalid: got %0h expected 1", arvalid); end
    vectors++; if (araddr !== 32'h0001_2348) begin miscompares++; $display("FAIL single_araddr: got %h expected 00012348", araddr); end
    vectors++; if ({arlen, arsize, arburst} !== {4'd7, 3'd3, 2'd2}) begin miscompares++; $display("FAIL single_arattr: got %0d/%0d/%0d expected 7/3/2", arlen, arsize, arburst); end
    vectors++; if (miss_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready_busy: got %0h expected 0", miss_ready); end
    tick();
    vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL single_arvalid_drop: got %0h expected 0", arvalid); end
    vectors++; if (fifo_rdata !== 32'h0001_2348) begin miscompares++; $display("FAIL single_rdata: got %h expected 00012348", fifo_rdata); end
    vectors++; if (fifo_empty !== 1'b0) begin miscompares++; $display("FAIL single_empty: got %0h expected 0", fifo_empty); end
    vectors++; if (outstanding !== 3'd1) begin miscompares++; $display("FAIL single_outstanding: got %0d expected 1", outstanding); end
    fifo_rden = 1'b1; tick(); fifo_rden = 1'b0;
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL single_pop: got %0d expected 0", outstanding); end
  endtask

  task automatic test_backpressure();
    arready = 1'b0; miss_req = 1'b1; miss_addr = 32'h0000_1007;
    tick();
    miss_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (arvalid !== 1'b1 || araddr !== 32'h0000_1000 || miss_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got v=%0h a=%h r=%0h expected v=1 a=00001000 r=0", i, arvalid, araddr, miss_ready);
      end
      tick();
    end
    arready = 1'b1;
    tick();
    vectors++; if (arvalid !== 1'b0 || miss_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got v=%0h r=%0h expected v=0 r=1", arvalid, miss_ready); end
    vectors++; if (fifo_rdata !== 32'h0000_1007) begin miscompares++; $display("FAIL bp_rdata: got %h expected 00001007", fifo_rdata); end
    fifo_rden = 1'b1; tick(); fifo_rden = 1'b0;
  endtask

  task automatic test_fill_fifo();
    logic [31:0] a [5];
    for (int i = 0; i < 5; i++) a[i] = 32'h0000_4000 + 32'(i) * 32'h44;
    arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      miss_req = 1'b1; miss_addr = a[i];
      #1;
      vectors++; if (miss_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready[%0d]: got %0h expected 1", i, miss_ready); end
      tick();
      miss_req = 1'b0;
      vectors++; if (outstanding !== 3'(i + 1)) begin miscompares++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, outstanding, i + 1); end
      tick();
    end
    miss_req = 1'b1; miss_addr = a[4];
    #1;
    vectors++; if (miss_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %0h expected 0", miss_ready); end
    tick();
    vectors++; if (arvalid !== 1'b0 || outstanding !== 3'd4) begin miscompares++; $display("FAIL full_hold: got v=%0h n=%0d expected v=0 n=4", arvalid, outstanding); end
    vectors++; if (fifo_rdata !== a[0]) begin miscompares++; $display("FAIL full_head: got %h expected %h", fifo_rdata, a[0]); end
    fifo_rden = 1'b1;
    #1;
    vectors++; if (miss_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop_same_cycle: got %0h expected 0", miss_ready); end
    tick();
    fifo_rden = 1'b0;
    #1;
    vectors++; if (miss_ready !== 1'b1 || outstanding !== 3'd3) begin miscompares++; $display("FAIL after_pop: got r=%0h n=%0d expected r=1 n=3", miss_ready, outstanding); end
    tick();
    miss_req = 1'b0;
    vectors++; if (arvalid !== 1'b1 || outstanding !== 3'd4 || araddr !== {a[4][31:3], 3'b000}) begin
      miscompares++; $display("FAIL fifth_accept: got v=%0h n=%0d a=%h expected v=1 n=4 a=%h", arvalid, outstanding, araddr, {a[4][31:3], 3'b000});
    end
    tick();
    for (int i = 1; i < 5; i++) begin
      vectors++; if (fifo_rdata !== a[i]) begin miscompares++; $display("FAIL pop_order[%0d]: got %h expected %h", i, fifo_rdata, a[i]); end
      fifo_rden = 1'b1; tick(); fifo_rden = 1'b0;
    end
    vectors++; if (fifo_empty !== 1'b1 || outstanding !== 3'd0) begin miscompares++; $display("FAIL fill_drained: got e=%0h n=%0d expected e=1 n=0", fifo_empty, outstanding); end
  endtask

  task automatic test_pop_empty();
    fifo_rden = 1'b1; tick(); tick(); fifo_rden = 1'b0;
    vectors++; if (fifo_empty !== 1'b1 || outstanding !== 3'd0) begin miscompares++; $display("FAIL pop_empty: got e=%0h n=%0d expected e=1 n=0", fifo_empty, outstanding); end
    arready = 1'b1; miss_req = 1'b1; miss_addr = 32'hCAFE_0010;
    tick(); miss_req = 1'b0; tick();
    vectors++; if (outstanding !== 3'd1 || fifo_rdata !== 32'hCAFE_0010) begin miscompares++; $display("FAIL pop_empty_push: got n=%0d d=%h expected n=1 d=cafe0010", outstanding, fifo_rdata); end
    fifo_rden = 1'b1; tick(); fifo_rden = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    arready = 1'b1;
    miss_req = 1'b1; miss_addr = 32'h0000_8000; tick(); miss_req = 1'b0; tick();
    miss_req = 1'b1; miss_addr = 32'h0000_8040; tick(); miss_req = 1'b0; tick();
    vectors++; if (outstanding !== 3'd2) begin miscompares++; $display("FAIL simul_pre: got %0d expected 2", outstanding); end
    miss_req = 1'b1; miss_addr = 32'h0000_8080; fifo_rden = 1'b1;
    tick();
    miss_req = 1'b0; fifo_rden = 1'b0;
    vectors++; if (outstanding !== 3'd2 || fifo_rdata !== 32'h0000_8040) begin miscompares++; $display("FAIL simul_both: got n=%0d d=%h expected n=2 d=00008040", outstanding, fifo_rdata); end
    tick();
    fifo_rden = 1'b1; tick(); tick(); fifo_rden = 1'b0;
    vectors++; if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL simul_drain: got %0h expected 1", fifo_empty); end
    miss_req = 1'b1; miss_addr = 32'h0000_90C0; fifo_rden = 1'b1;
    tick();
    miss_req = 1'b0; fifo_rden = 1'b0;
    vectors++; if (outstanding !== 3'd1 || fifo_rdata !== 32'h0000_90C0) begin miscompares++; $display("FAIL simul_empty: got n=%0d d=%h expected n=1 d=000090c0", outstanding, fifo_rdata); end
    tick();
  endtask

  task automatic test_async_reset();
    arready = 1'b0; miss_req = 1'b1; miss_addr = 32'h0000_A008;
    tick();
    miss_req = 1'b0;
    vectors++; if (arvalid !== 1'b1 || outstanding !== 3'd2) begin miscompares++; $display("FAIL areset_pre: got v=%0h n=%0d expected v=1 n=2", arvalid, outstanding); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (arvalid !== 1'b0 || fifo_empty !== 1'b1 || outstanding !== 3'd0 || miss_ready !== 1'b0) begin
      miscompares++; $display("FAIL areset_now: got v=%0h e=%0h n=%0d r=%0h expected v=0 e=1 n=0 r=0", arvalid, fifo_empty, outstanding, miss_ready);
    end
    tick();
    rst = 1'b0; arready = 1'b1;
    #1;
    vectors++; if (miss_ready !== 1'b1 || araddr !== 32'h0) begin miscompares++; $display("FAIL areset_after: got r=%0h a=%h expected r=1 a=0", miss_ready, araddr); end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_backpressure();
    test_fill_fifo();
    test_pop_empty();
    test_simul_push_pop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
